// File: rtl/shared_pkg.sv
// Shared GLB definitions: bank select enum, default widths and FSM state
// encoding for the GLB load and unload paths.
package shared_pkg;

  localparam int GLB_DATA_WIDTH = 64;
  localparam int GLB_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    IFMAP  = 2'd0,
    FILTER = 2'd1,
    BIAS   = 2'd2,
    PSUM   = 2'd3
  } data_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } unload_state_t;

endpackage

// File: rtl/glb_rd_skid.sv
// Two-entry FIFO of {data, idx} absorbing GLB read latency and DRAM stalls.
// Ports: push/push_data/push_idx in, pop in, occupancy and head out.
module glb_rd_skid #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [ADDR_WIDTH-1:0] push_idx,
  input  logic                  pop,
  output logic [1:0]            occupancy,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [ADDR_WIDTH-1:0] head_idx
);

  logic [DATA_WIDTH-1:0] data_q [2];
  logic [DATA_WIDTH-1:0] data_d [2];
  logic [ADDR_WIDTH-1:0] idx_q  [2];
  logic [ADDR_WIDTH-1:0] idx_d  [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;

  always_comb begin
    data_d   = data_q;
    idx_d    = idx_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      data_d[wr_ptr_q] = push_data;
      idx_d[wr_ptr_q]  = push_idx;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        idx_q[i]  <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      data_q   <= data_d;
      idx_q    <= idx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign occupancy = count_q;
  assign head_data = data_q[rd_ptr_q];
  assign head_idx  = idx_q[rd_ptr_q];

endmodule

// File: rtl/glb_unload_reader.sv
// Streams num_words GLB words from base_addr to a DRAM valid/ready stream.
// Ports: start/data_type/base_addr/num_words in; busy/done status;
// glb_rd_* GLB read port; dram_w* output stream with dram_wready in.
module glb_unload_reader
  import shared_pkg::*;
#(
  parameter int DATA_WIDTH = GLB_DATA_WIDTH,
  parameter int ADDR_WIDTH = GLB_ADDR_WIDTH
) (
  input  logic                  core_clk,
  input  logic                  reset,
  input  logic                  start,
  input  data_t                 data_type,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] num_words,
  output logic                  busy,
  output logic                  done,
  output data_t                 glb_rd_sel,
  output logic                  glb_rd_en,
  output logic [ADDR_WIDTH-1:0] glb_rd_addr,
  input  logic [DATA_WIDTH-1:0] glb_rd_data,
  output logic [DATA_WIDTH-1:0] dram_wdata,
  output logic [ADDR_WIDTH-1:0] dram_widx,
  output logic                  dram_wvalid,
  input  logic                  dram_wready
);

  unload_state_t         state_q, state_d;
  data_t                 sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] num_q, num_d;
  logic [ADDR_WIDTH-1:0] issued_q, issued_d;
  logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic                  inflight_q, inflight_d;

  logic [1:0] occ;
  logic       pop;
  logic [2:0] credit;

  glb_rd_skid #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_skid (
    .clk       (core_clk),
    .rst       (reset),
    .push      (inflight_q),
    .push_data (glb_rd_data),
    .push_idx  (rd_idx_q),
    .pop       (pop),
    .occupancy (occ),
    .head_data (dram_wdata),
    .head_idx  (dram_widx)
  );

  assign dram_wvalid = (occ != 2'd0);
  assign pop         = dram_wvalid && dram_wready;

  // Slots committed after this cycle: buffered + returning - leaving.
  assign credit = 3'(occ) + 3'(inflight_q) - 3'(pop);

  assign glb_rd_addr = base_q + issued_q;
  assign glb_rd_sel  = sel_q;
  assign busy        = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    base_d    = base_q;
    num_d     = num_q;
    issued_d  = issued_q;
    rd_idx_d  = rd_idx_q;
    glb_rd_en = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_d    = data_type;
          base_d   = base_addr;
          num_d    = num_words;
          issued_d = '0;
          state_d  = (num_words == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (issued_q == num_q) begin
          state_d = ST_DRAIN;
        end else if (credit < 3'd2) begin
          glb_rd_en = 1'b1;
          rd_idx_d  = issued_q;
          issued_d  = issued_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // The last word may leave this cycle; nothing else can arrive.
        if (!inflight_q && (occ == {1'b0, pop})) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    inflight_d = glb_rd_en;
  end

  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= IFMAP;
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      rd_idx_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      base_q     <= base_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      rd_idx_q   <= rd_idx_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_glb_unload_reader.sv
// Scoreboard bench for glb_unload_reader: stimulus queues expected reads
// and words, a negedge monitor pops and compares what the DUT presents.
module tb_glb_unload_reader;
  import shared_pkg::*;

  logic        core_clk = 1'b0;
  logic        reset;
  logic        start;
  data_t       data_type;
  logic [11:0] base_addr;
  logic [11:0] num_words;
  logic        busy;
  logic        done;
  data_t       glb_rd_sel;
  logic        glb_rd_en;
  logic [11:0] glb_rd_addr;
  logic [63:0] glb_rd_data;
  logic [63:0] dram_wdata;
  logic [11:0] dram_widx;
  logic        dram_wvalid;
  logic        dram_wready;

  glb_unload_reader dut (
    .core_clk    (core_clk),
    .reset       (reset),
    .start       (start),
    .data_type   (data_type),
    .base_addr   (base_addr),
    .num_words   (num_words),
    .busy        (busy),
    .done        (done),
    .glb_rd_sel  (glb_rd_sel),
    .glb_rd_en   (glb_rd_en),
    .glb_rd_addr (glb_rd_addr),
    .glb_rd_data (glb_rd_data),
    .dram_wdata  (dram_wdata),
    .dram_widx   (dram_widx),
    .dram_wvalid (dram_wvalid),
    .dram_wready (dram_wready)
  );

  always #5 core_clk = ~core_clk;

  typedef struct {
    logic [63:0] d;
    logic [11:0] i;
  } exp_t;

  typedef struct {
    logic [11:0] a;
    data_t       s;
  } rd_t;

  exp_t exp_word[$];
  rd_t  exp_rd[$];

  int vecs = 0;
  int miss = 0;

  int unsigned edge_cnt = 0;
  int  s_edge = 0;
  int  run_id = 0;
  int  seen_id = 0;
  bit  pat_mode = 0;
  logic [3:0] pat = 4'b1001;

  int first_en, first_v, last_v, done_rel;
  int done_cnt, n_rd, n_pop, max_out;
  bit busy_seen, stalled;
  logic [63:0] hold_d;
  logic [11:0] hold_i;

  function automatic logic [63:0] gdat(data_t s, logic [11:0] a);
    return {14'h0, s, 4'h0, a, 16'hC0DE, 4'h0, a ^ 12'hFFF};
  endfunction

  always @(posedge core_clk) edge_cnt <= edge_cnt + 1;

  always @(posedge core_clk) begin
    if (glb_rd_en) glb_rd_data <= gdat(glb_rd_sel, glb_rd_addr);
    else glb_rd_data <= 64'hDEAD_BEEF_DEAD_BEEF;
  end

  always @(posedge core_clk) begin
    #1;
    dram_wready = pat_mode ? pat[edge_cnt[1:0]] : 1'b1;
  end

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    vecs++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge core_clk) begin
    int rel;
    int o;
    rd_t  r;
    exp_t e;
    if (seen_id != run_id) begin
      seen_id   = run_id;
      first_en  = -1;
      first_v   = -1;
      last_v    = -1;
      done_rel  = -1;
      done_cnt  = 0;
      n_rd      = 0;
      n_pop     = 0;
      max_out   = 0;
      busy_seen = 0;
      stalled   = 0;
    end
    if (!reset) begin
      rel = int'(edge_cnt) - s_edge + 1;
      o = n_rd - n_pop;
      if (o > max_out) max_out = o;
      if (busy) busy_seen = 1;
      if (glb_rd_en) begin
        if (first_en < 0) first_en = rel;
        n_rd++;
        vecs++;
        if (exp_rd.size() == 0) begin
          miss++;
          $display("FAIL rd_extra: addr %h not expected", glb_rd_addr);
        end else begin
          r = exp_rd.pop_front();
          if (glb_rd_addr !== r.a || glb_rd_sel !== r.s) begin
            miss++;
            $display("FAIL rd_addr: got %h/%0d expected %h/%0d",
                     glb_rd_addr, glb_rd_sel, r.a, r.s);
          end
        end
      end
      if (dram_wvalid) begin
        if (first_v < 0) first_v = rel;
        last_v = rel;
        if (stalled) begin
          vecs++;
          if (dram_wdata !== hold_d || dram_widx !== hold_i) begin
            miss++;
            $display("FAIL stall_hold: got %h/%0d expected %h/%0d",
                     dram_wdata, dram_widx, hold_d, hold_i);
          end
        end
        if (dram_wready) begin
          n_pop++;
          vecs++;
          if (exp_word.size() == 0) begin
            miss++;
            $display("FAIL word_extra: idx %0d not expected", dram_widx);
          end else begin
            e = exp_word.pop_front();
            if (dram_wdata !== e.d || dram_widx !== e.i) begin
              miss++;
              $display("FAIL word: got %h/%0d expected %h/%0d",
                       dram_wdata, dram_widx, e.d, e.i);
            end
          end
        end
        stalled = !dram_wready;
        hold_d  = dram_wdata;
        hold_i  = dram_widx;
      end else begin
        stalled = 0;
      end
      if (done) begin
        done_cnt++;
        done_rel = rel;
      end
    end
  end

  task automatic launch(input data_t s, input logic [11:0] b,
                        input logic [11:0] n, input bit dbl);
    logic [11:0] a;
    run_id++;
    for (int i = 0; i < int'(n); i++) begin
      a = b + 12'(i);
      exp_rd.push_back('{a: a, s: s});
      exp_word.push_back('{d: gdat(s, a), i: 12'(i)});
    end
    @(posedge core_clk); #1;
    start     = 1'b1;
    data_type = s;
    base_addr = b;
    num_words = n;
    @(posedge core_clk); #1;
    s_edge    = int'(edge_cnt);
    start     = 1'b0;
    data_type = data_t'($urandom_range(3));
    base_addr = 12'($urandom);
    num_words = 12'($urandom);
    if (dbl) begin
      @(posedge core_clk); #1;
      start     = 1'b1;
      base_addr = b + 12'h100;
      num_words = n + 12'd3;
      @(posedge core_clk); #1;
      start     = 1'b0;
    end
  endtask

  task automatic wait_done(input string nm, input int lim);
    int k;
    k = 0;
    while (done_cnt == 0 && k < lim) begin
      @(posedge core_clk);
      k++;
    end
    chk({nm, "_timeout"}, done_cnt == 0, 0);
    repeat (3) @(posedge core_clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_busy"},  busy, 0);
    chk({nm, "_done"},  done, 0);
    chk({nm, "_rden"},  glb_rd_en, 0);
    chk({nm, "_valid"}, dram_wvalid, 0);
    chk({nm, "_addr"},  glb_rd_addr, 0);
    chk({nm, "_wdata"}, dram_wdata, 0);
    chk({nm, "_widx"},  dram_widx, 0);
    chk({nm, "_sel"},   glb_rd_sel, IFMAP);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    data_type = IFMAP;
    base_addr = '0;
    num_words = '0;
    repeat (3) @(posedge core_clk);
    #1;
    chk_reset_outs("rst");
    reset = 1'b0;

    launch(PSUM, 12'h010, 12'd4, 0);
    wait_done("basic", 50);
    chk("basic_first_en", first_en, 1);
    chk("basic_first_v", first_v, 3);
    chk("basic_last_v", last_v, 6);
    chk("basic_done", done_rel, 7);
    chk("basic_done_cnt", done_cnt, 1);
    chk("basic_words", n_pop, 4);
    chk("basic_left", exp_word.size(), 0);

    pat_mode = 1;
    launch(FILTER, 12'h200, 12'd8, 0);
    wait_done("bp", 200);
    pat_mode = 0;
    chk("bp_words", n_pop, 8);
    chk("bp_over2", max_out > 2, 0);
    chk("bp_done_cnt", done_cnt, 1);
    chk("bp_left", exp_word.size(), 0);

    launch(BIAS, 12'h123, 12'd0, 0);
    wait_done("zero", 20);
    chk("zero_done", done_rel, 1);
    chk("zero_rden", first_en, -1);
    chk("zero_valid", first_v, -1);
    chk("zero_busy", busy_seen, 0);

    launch(IFMAP, 12'hFFE, 12'd4, 0);
    wait_done("wrap", 50);
    chk("wrap_reads", n_rd, 4);
    chk("wrap_done", done_rel, 7);
    chk("wrap_left", exp_rd.size(), 0);

    launch(PSUM, 12'h040, 12'd5, 1);
    wait_done("dbl", 50);
    repeat (5) @(posedge core_clk);
    #1;
    chk("dbl_done_cnt", done_cnt, 1);
    chk("dbl_reads", n_rd, 5);
    chk("dbl_done", done_rel, 8);
    chk("dbl_left", exp_word.size(), 0);

    launch(FILTER, 12'h300, 12'd16, 0);
    repeat (2) @(posedge core_clk);
    #3;
    reset = 1'b1;
    #1;
    chk_reset_outs("abort");
    exp_rd.delete();
    exp_word.delete();
    @(posedge core_clk); #1;
    reset = 1'b0;
    repeat (25) @(posedge core_clk);
    #1;
    chk("abort_done", done_cnt, 0);
    chk("abort_busy", busy, 0);

    launch(BIAS, 12'h7F0, 12'd2, 0);
    wait_done("post", 50);
    chk("post_done", done_rel, 5);
    chk("post_words", n_pop, 2);
    chk("post_left", exp_word.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
